// File: rtl/control_filtro_iir_pkg.sv
// Shared encodings for the biquad IIR control FSM: state codes, mux select codes
// and the per-operation select/enable table.
package control_filtro_iir_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_OP1, ST_OP2, ST_OP3, ST_OP4, ST_OP5, ST_SHIFT, ST_DONE
  } estado_t;

  typedef enum logic [2:0] {SEL_FK, SEL_FK1, SEL_FK2, SEL_YK, SEL_UK} sel_s_t;
  typedef enum logic [1:0] {SEL_MA1, SEL_MA2, SEL_B0, SEL_B1} sel_c_t;
  typedef enum logic [2:0] {SEL_ZERO, SEL_ZUK, SEL_ACUM1, SEL_ACUM2, SEL_ACUM3} sel_z_t;

  typedef struct packed {
    sel_s_t     s;
    sel_c_t     c;
    sel_z_t     z;
    logic [7:1] en;
  } op_t;

  function automatic logic is_op(estado_t st);
    return (st == ST_OP1) || (st == ST_OP2) || (st == ST_OP3) ||
           (st == ST_OP4) || (st == ST_OP5);
  endfunction

  // b2 equals b0, so OP5 reuses the b0 coefficient code.
  function automatic op_t op_decode(estado_t st);
    op_t op;
    op = '{s: SEL_FK, c: SEL_MA1, z: SEL_ZERO, en: 7'b0};
    case (st)
      ST_OP1:  op = '{s: SEL_FK1, c: SEL_MA1, z: SEL_ZUK,   en: 7'b0010000};
      ST_OP2:  op = '{s: SEL_FK2, c: SEL_MA2, z: SEL_ACUM1, en: 7'b0000010};
      ST_OP3:  op = '{s: SEL_FK,  c: SEL_B0,  z: SEL_ZERO,  en: 7'b0100000};
      ST_OP4:  op = '{s: SEL_FK1, c: SEL_B1,  z: SEL_ACUM2, en: 7'b1000000};
      ST_OP5:  op = '{s: SEL_FK2, c: SEL_B0,  z: SEL_ACUM3, en: 7'b0000001};
      default: op = '{s: SEL_FK,  c: SEL_MA1, z: SEL_ZERO,  en: 7'b0};
    endcase
    return op;
  endfunction

endpackage

// File: rtl/control_filtro_iir_if.sv
// Control bundle between the sample-timing side (master) and the IIR sequencer (slave).
interface control_filtro_iir_if;
  logic       start;
  logic       en1, en2, en3, en4, en5, en6, en7;
  logic [2:0] selmuxS;
  logic [1:0] selmuxC;
  logic [2:0] selmuxZ;
  logic       busy;
  logic       done;
  logic       overrun;

  modport master (
    output start,
    input  en1, en2, en3, en4, en5, en6, en7,
    input  selmuxS, selmuxC, selmuxZ, busy, done, overrun
  );

  modport slave (
    input  start,
    output en1, en2, en3, en4, en5, en6, en7,
    output selmuxS, selmuxC, selmuxZ, busy, done, overrun
  );
endinterface

// File: rtl/control_filtro_iir_contador_espera.sv
// Wait counter for the arithmetic latency: cleared on request, flags the
// terminal count when it reaches ARIT_LAT.
module control_filtro_iir_contador_espera #(
  parameter int ARIT_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tc
);
  localparam int CW = (ARIT_LAT < 1) ? 1 : $clog2(ARIT_LAT + 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = clr ? '0 : count_reg + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) count_reg <= '0;
    else       count_reg <= count_next;
  end

  assign tc = (count_reg == CW'(ARIT_LAT));
endmodule

// File: rtl/control_filtro_iir.sv
// Control FSM sequencing the biquad IIR datapath: five multiply-add steps,
// a history shift and a done pulse per accepted start strobe.
module control_filtro_iir
  import control_filtro_iir_pkg::*;
#(
  parameter int ARIT_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  control_filtro_iir_if.slave       bus
);
  estado_t    state_reg;
  estado_t    state_next;
  logic       tc;
  logic       in_op;
  op_t        op;
  logic [7:1] en_vec;

  assign in_op = is_op(state_reg);

  // Counter runs only inside an OPn and restarts at each OP boundary,
  // so every OPn sees a fresh count on entry.
  control_filtro_iir_contador_espera #(
    .ARIT_LAT(ARIT_LAT)
  ) u_espera (
    .clk  (clk),
    .reset(reset),
    .clr  (!in_op || tc),
    .tc   (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (bus.start) state_next = ST_OP1;
      ST_OP1:   if (tc) state_next = ST_OP2;
      ST_OP2:   if (tc) state_next = ST_OP3;
      ST_OP3:   if (tc) state_next = ST_OP4;
      ST_OP4:   if (tc) state_next = ST_OP5;
      ST_OP5:   if (tc) state_next = ST_SHIFT;
      ST_SHIFT: state_next = ST_DONE;
      ST_DONE:  state_next = bus.start ? ST_OP1 : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Enables depend only on state and counter; start reaches only overrun.
  always_comb begin
    op          = op_decode(state_reg);
    en_vec      = '0;
    bus.selmuxS = 3'd0;
    bus.selmuxC = 2'd0;
    bus.selmuxZ = 3'd0;
    if (in_op) begin
      bus.selmuxS = op.s;
      bus.selmuxC = op.c;
      bus.selmuxZ = op.z;
      if (tc) en_vec = op.en;
    end
    if (state_reg == ST_SHIFT) begin
      en_vec[3] = 1'b1;
      en_vec[4] = 1'b1;
    end
    bus.busy    = (state_reg != ST_IDLE);
    bus.done    = (state_reg == ST_DONE);
    bus.overrun = bus.start && !reset && (in_op || state_reg == ST_SHIFT);
  end

  assign bus.en1 = en_vec[1];
  assign bus.en2 = en_vec[2];
  assign bus.en3 = en_vec[3];
  assign bus.en4 = en_vec[4];
  assign bus.en5 = en_vec[5];
  assign bus.en6 = en_vec[6];
  assign bus.en7 = en_vec[7];
endmodule

// File: tb/tb_control_filtro_iir.sv
// Scoreboard bench for control_filtro_iir: two instances (ARIT_LAT 1 and 2),
// expected per-cycle outputs queued at start time and compared every cycle.
module tb_control_filtro_iir;

  typedef struct packed {
    logic [7:1] en;
    logic [2:0] s;
    logic [1:0] c;
    logic [2:0] z;
    logic       busy;
    logic       done;
    logic       overrun;
  } vec_t;

  typedef struct {
    int   cyc;
    vec_t v;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_tests;
  int   n_fail;
  int   cyc;
  int   t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  control_filtro_iir_if ifa();
  control_filtro_iir_if ifb();

  control_filtro_iir #(.ARIT_LAT(1)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
  control_filtro_iir #(.ARIT_LAT(2)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic vec_t sample_a();
    vec_t v;
    v.en      = {ifa.en7, ifa.en6, ifa.en5, ifa.en4, ifa.en3, ifa.en2, ifa.en1};
    v.s       = ifa.selmuxS;
    v.c       = ifa.selmuxC;
    v.z       = ifa.selmuxZ;
    v.busy    = ifa.busy;
    v.done    = ifa.done;
    v.overrun = ifa.overrun;
    return v;
  endfunction

  function automatic vec_t sample_b();
    vec_t v;
    v.en      = {ifb.en7, ifb.en6, ifb.en5, ifb.en4, ifb.en3, ifb.en2, ifb.en1};
    v.s       = ifb.selmuxS;
    v.c       = ifb.selmuxC;
    v.z       = ifb.selmuxZ;
    v.busy    = ifb.busy;
    v.done    = ifb.done;
    v.overrun = ifb.overrun;
    return v;
  endfunction

  task automatic push_e(input int which, input exp_t e);
    if (which == 0) qa.push_back(e);
    else            qb.push_back(e);
  endtask

  // Expected outputs for a sequence whose start is sampled in cycle t0.
  task automatic push_seq(input int which, input int t0, input int lat);
    int   s_tab[5]  = '{1, 2, 0, 1, 2};
    int   c_tab[5]  = '{0, 1, 2, 3, 2};
    int   z_tab[5]  = '{1, 2, 0, 3, 4};
    int   en_tab[5] = '{5, 2, 6, 7, 1};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k <= lat; k++) begin
        e.cyc  = t0 + 1 + i * (lat + 1) + k;
        e.v    = '0;
        e.v.s  = 3'(s_tab[i]);
        e.v.c  = 2'(c_tab[i]);
        e.v.z  = 3'(z_tab[i]);
        e.v.busy = 1'b1;
        if (k == lat) e.v.en[en_tab[i]] = 1'b1;
        push_e(which, e);
      end
    end
    e.cyc = t0 + 5 * (lat + 1) + 1;
    e.v = '0;
    e.v.en[3] = 1'b1;
    e.v.en[4] = 1'b1;
    e.v.busy = 1'b1;
    push_e(which, e);
    e.cyc = t0 + 5 * (lat + 1) + 2;
    e.v = '0;
    e.v.busy = 1'b1;
    e.v.done = 1'b1;
    push_e(which, e);
  endtask

  task automatic mark_overrun_a(input int c);
    for (int i = 0; i < qa.size(); i++)
      if (qa[i].cyc == c) qa[i].v.overrun = 1'b1;
  endtask

  task automatic flush_after_a(input int c);
    while (qa.size() > 0 && qa[qa.size()-1].cyc > c) void'(qa.pop_back());
  endtask

  task automatic step(input logic sa, input logic ra, input logic sb, input logic rb);
    exp_t e;
    vec_t ev;
    @(negedge clk);
    ifa.start = sa;
    rst_a     = ra;
    ifb.start = sb;
    rst_b     = rb;
    #1;
    ev = '0;
    if (qa.size() > 0 && qa[0].cyc == cyc) begin
      e  = qa.pop_front();
      ev = e.v;
    end
    check($sformatf("A_lat1 cyc%0d", cyc), 32'(sample_a()), 32'(ev));
    ev = '0;
    if (qb.size() > 0 && qb[0].cyc == cyc) begin
      e  = qb.pop_front();
      ev = e.v;
    end
    check($sformatf("B_lat2 cyc%0d", cyc), 32'(sample_b()), 32'(ev));
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    rst_a     = 1'b1;
    rst_b     = 1'b1;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    @(posedge clk);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Single sample, ARIT_LAT=1: enables, selects, busy, done timing.
    t = cyc;
    push_seq(0, t, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(15);

    // Overrun in OP3 and SHIFT, then back-to-back start in DONE.
    t = cyc;
    push_seq(0, t, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    mark_overrun_a(t + 5);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    mark_overrun_a(t + 11);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    push_seq(0, t + 12, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(15);

    // Reset mid-sequence (with start also high: reset wins), restart after.
    t = cyc;
    push_seq(0, t, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    flush_after_a(t + 7);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    push_seq(0, t + 9, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(15);

    // Reset while idle beats start: nothing launches.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);

    // ARIT_LAT=2 instance: en5@3, en1@15, done@17.
    t = cyc;
    push_seq(1, t, 2);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(20);

    if (qa.size() != 0 || qb.size() != 0) begin
      check("scoreboard_drain", 32'(qa.size() + qb.size()), 32'd0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
